// File: rtl/mem_lsu.sv
`timescale 1ns/1ps
// mem_lsu: memory stage. Issues byte/half/word loads and stores on the
// data-SRAM request/response bus, formats load data, and registers the
// result toward write-back. It stalls upstream while a transaction is open.
// Optional build macro: MEM_ALIGN_CHECK_EN (misaligned accesses trap
// instead of being forced to alignment).

`ifndef EXE_LD_B_OP
`define EXE_LD_B_OP  8'h28
`endif
`ifndef EXE_LD_H_OP
`define EXE_LD_H_OP  8'h29
`endif
`ifndef EXE_LD_W_OP
`define EXE_LD_W_OP  8'h2A
`endif
`ifndef EXE_ST_B_OP
`define EXE_ST_B_OP  8'h2B
`endif
`ifndef EXE_ST_H_OP
`define EXE_ST_H_OP  8'h2C
`endif
`ifndef EXE_ST_W_OP
`define EXE_ST_W_OP  8'h2D
`endif
`ifndef EXE_LD_BU_OP
`define EXE_LD_BU_OP 8'h2E
`endif
`ifndef EXE_LD_HU_OP
`define EXE_LD_HU_OP 8'h2F
`endif

module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [7:0]        aluop_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [31:0]       pc_i,
  input  logic [1:0]        excepttype_i,
  input  logic              flush_i,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_wstrb_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic              valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [31:0]       pc_o,
  output logic [1:0]        excepttype_o,
  output logic              stallreq
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  function automatic logic op_is_mem(input logic [7:0] op);
    case (op)
      `EXE_LD_B_OP, `EXE_LD_H_OP, `EXE_LD_W_OP, `EXE_LD_BU_OP, `EXE_LD_HU_OP,
      `EXE_ST_B_OP, `EXE_ST_H_OP, `EXE_ST_W_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    case (op)
      `EXE_ST_B_OP, `EXE_ST_H_OP, `EXE_ST_W_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] op_size(input logic [7:0] op);
    case (op)
      `EXE_LD_B_OP, `EXE_LD_BU_OP, `EXE_ST_B_OP: return 2'd0;
      `EXE_LD_H_OP, `EXE_LD_HU_OP, `EXE_ST_H_OP: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // Low address bits with alignment forced for half and word accesses
  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'd0: return lo;
      2'd1: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0: return 4'b0001 << off;
      2'd1: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0] sz, input logic [DATA_W-1:0] d);
    case (sz)
      2'd0: return {4{d[7:0]}};
      2'd1: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_fmt(input logic [7:0] op, input logic [1:0] off,
                                                 input logic [DATA_W-1:0] rdata);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    case (off)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h   = off[1] ? rdata[31:16] : rdata[15:0];
    b_s = b;
    h_s = h;
    case (op)
      `EXE_LD_B_OP:  return DATA_W'(b_s);
      `EXE_LD_BU_OP: return DATA_W'(b);
      `EXE_LD_H_OP:  return DATA_W'(h_s);
      `EXE_LD_HU_OP: return DATA_W'(h);
      default:       return rdata;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return ((sz == 2'd1) && lo[0]) || ((sz == 2'd2) && (lo != 2'b00));
  endfunction
`endif

  state_t state, state_nxt;

  logic [7:0]        aluop_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [1:0]        size_p1;
  logic              wr_p1;
  logic [3:0]        wstrb_p1;
  logic [DATA_W-1:0] wlane_p1;
  logic [4:0]        wd_p1;
  logic              wreg_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [31:0]       pc_p1;
  logic [1:0]        exc_p1;
  logic              kill_p1;

  logic              vld_p2;
  logic [4:0]        wd_p2;
  logic              wreg_p2;
  logic [DATA_W-1:0] wdata_p2;
  logic [31:0]       pc_p2;
  logic [1:0]        exc_p2;

  logic       in_mem, in_store, in_mis;
  logic [1:0] in_size, in_off;
  logic       accept_mem, accept_direct, done, kill_now;

  assign in_mem   = op_is_mem(aluop_i);
  assign in_store = op_is_store(aluop_i);
  assign in_size  = op_size(aluop_i);
  assign in_off   = align_off(in_size, mem_addr_i[1:0]);
`ifdef MEM_ALIGN_CHECK_EN
  assign in_mis   = in_mem && misaligned(in_size, mem_addr_i[1:0]);
`else
  assign in_mis   = 1'b0;
`endif

  // Misaligned (trapping) mem ops take the single-cycle path like ALU results
  assign accept_mem    = (state == IDLE) && valid_i && !flush_i && in_mem && !in_mis;
  assign accept_direct = (state == IDLE) && valid_i && !flush_i && !(in_mem && !in_mis);
  assign done          = ((state == REQ) && data_addr_ok_i && data_data_ok_i) ||
                         ((state == WAIT) && data_data_ok_i);
  assign kill_now      = kill_p1 | flush_i;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a flush in REQ without addr_ok withdraws the request
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_mem) state_nxt = REQ;
      REQ: begin
        if (data_addr_ok_i)  state_nxt = data_data_ok_i ? IDLE : WAIT;
        else if (flush_i)    state_nxt = IDLE;
      end
      WAIT: if (data_data_ok_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request and stall; both forced low while reset is asserted
  always_comb begin
    data_req_o = rst && (state == REQ);
    stallreq   = rst && (accept_mem || (((state == REQ) || (state == WAIT)) && !done));
  end

  // Kill flag: an accepted request that was flushed still drains its response
  always_ff @(posedge clk) begin
    if (!rst)                                                 kill_p1 <= 1'b0;
    else if (accept_mem)                                      kill_p1 <= 1'b0;
    else if ((state == REQ) && data_addr_ok_i && !data_data_ok_i) kill_p1 <= flush_i;
    else if (state == WAIT)                                   kill_p1 <= kill_p1 | flush_i;
  end

  // ---- stage p1: latched request, held stable on the bus until accepted ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      aluop_p1 <= '0;
      addr_p1  <= '0;
      size_p1  <= '0;
      wr_p1    <= 1'b0;
      wstrb_p1 <= '0;
      wlane_p1 <= '0;
      wd_p1    <= '0;
      wreg_p1  <= 1'b0;
      wdata_p1 <= '0;
      pc_p1    <= '0;
      exc_p1   <= '0;
    end else if (accept_mem) begin
      aluop_p1 <= aluop_i;
      addr_p1  <= {mem_addr_i[ADDR_W-1:2], in_off};
      size_p1  <= in_size;
      wr_p1    <= in_store;
      wstrb_p1 <= in_store ? store_strb(in_size, in_off) : 4'b0000;
      wlane_p1 <= in_store ? store_lanes(in_size, reg2_i) : '0;
      wd_p1    <= wd_i;
      wreg_p1  <= wreg_i;
      wdata_p1 <= wdata_i;
      pc_p1    <= pc_i;
      exc_p1   <= excepttype_i;
    end
  end

  assign data_wr_o    = wr_p1;
  assign data_size_o  = size_p1;
  assign data_addr_o  = addr_p1;
  assign data_wstrb_o = wstrb_p1;
  assign data_wdata_o = wlane_p1;

  // ---- stage p2: write-back result, valid for exactly one cycle ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p2   <= 1'b0;
      wd_p2    <= '0;
      wreg_p2  <= 1'b0;
      wdata_p2 <= '0;
      pc_p2    <= '0;
      exc_p2   <= '0;
    end else begin
      vld_p2 <= 1'b0;
      if (accept_direct) begin
        vld_p2   <= 1'b1;
        wd_p2    <= wd_i;
        wreg_p2  <= wreg_i && !in_mis;
        wdata_p2 <= wdata_i;
        pc_p2    <= pc_i;
        exc_p2   <= excepttype_i | {in_mis, 1'b0};
      end else if (done && !kill_now) begin
        vld_p2   <= 1'b1;
        wd_p2    <= wd_p1;
        wreg_p2  <= wreg_p1 && !wr_p1;
        wdata_p2 <= wr_p1 ? wdata_p1 : load_fmt(aluop_p1, addr_p1[1:0], data_rdata_i);
        pc_p2    <= pc_p1;
        exc_p2   <= exc_p1;
      end
    end
  end

  assign valid_o      = vld_p2;
  assign wd_o         = wd_p2;
  assign wreg_o       = wreg_p2;
  assign wdata_o      = wdata_p2;
  assign pc_o         = pc_p2;
  assign excepttype_o = exc_p2;

endmodule
